// File: rtl/celement_arb_pkg.sv
// celement_arb_pkg
//   Shared definitions for the C-element round-robin arbiter:
//   - arb_state_t : handshake FSM states
//   - rr_pick     : round-robin selection of the next requester
//   - SYNC_DEPTH  : flop count of the optional input synchronizers
//                   (used when CELEM_ARB_SYNC_EN is defined)
package celement_arb_pkg;

   localparam int unsigned MAX_REQ    = 16;
   localparam int unsigned SYNC_DEPTH = 2;

   typedef enum logic [2:0] {
      IDLE,
      FWD,
      ACK,
      RTZ,
      DONE,
      ABSORB
   } arb_state_t;

   // First set bit of req at or above ptr, wrapping modulo n (n <= MAX_REQ).
   // Returns ptr unchanged when no bit is set; callers only use the result
   // when at least one request is pending.
   function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                          input logic [3:0]         ptr,
                                          input int unsigned        n);
      logic [3:0]  pick;
      logic        found;
      int unsigned idx;
      pick  = ptr;
      found = 1'b0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= n) idx = idx - n;
         if (!found && (k < n) && req[4'(idx)]) begin
            pick  = 4'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/celement_sync2.sv
// celement_sync2
//   Multi-bit flop-chain synchronizer (SYNC_DEPTH stages) with synchronous
//   active-high reset to zero. Instantiated by celement_rr_arbiter only when
//   CELEM_ARB_SYNC_EN is defined.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   d    in   WIDTH asynchronous inputs
//   q    out  WIDTH synchronized outputs
module celement_sync2
   import celement_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [SYNC_DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < SYNC_DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int unsigned i = 1; i < SYNC_DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[SYNC_DEPTH-1];

endmodule

// File: rtl/celement_rr_arbiter.sv
// celement_rr_arbiter
//   Round-robin arbiter sharing one downstream four-phase SEND/ACK channel
//   among N_REQ upstream C-element stages. Requesters whose EXBIN bit is 0
//   at grant are acknowledged locally without touching the downstream
//   channel. CP pulses for one cycle per completed forwarded transfer.
//   Build option: define CELEM_ARB_SYNC_EN to pass SENDIN/EXBIN/ACKIN through
//   2-flop synchronizers (all latencies grow by 2 cycles).
// Ports:
//   CLK       in   clock
//   RESET     in   synchronous active-high reset
//   SENDIN    in   N_REQ  per-requester 4-phase request
//   EXBIN     in   N_REQ  per-requester exclusion bit (1=forward, 0=absorb)
//   ACKOUT    out  N_REQ  per-requester acknowledge (one-hot or zero)
//   SENDOUT   out  downstream send
//   ACKIN     in   downstream acknowledge
//   GRANT_ID  out  ID_W  current grantee (valid while BUSY)
//   BUSY      out  high whenever the FSM is not IDLE
//   CP        out  one-cycle pulse on forwarded transfer completion
module celement_rr_arbiter
   import celement_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [N_REQ-1:0] SENDIN,
   input  logic [N_REQ-1:0] EXBIN,
   output logic [N_REQ-1:0] ACKOUT,
   output logic             SENDOUT,
   input  logic             ACKIN,
   output logic [ID_W-1:0]  GRANT_ID,
   output logic             BUSY,
   output logic             CP
);

   logic [N_REQ-1:0]   send_s;
   logic [N_REQ-1:0]   exb_s;
   logic               ack_s;

`ifdef CELEM_ARB_SYNC_EN
   logic [2*N_REQ:0] sync_q;

   celement_sync2 #(.WIDTH(2*N_REQ+1)) u_sync (
      .clk (CLK),
      .rst (RESET),
      .d   ({ACKIN, EXBIN, SENDIN}),
      .q   (sync_q)
   );

   assign {ack_s, exb_s, send_s} = sync_q;
`else
   assign send_s = SENDIN;
   assign exb_s  = EXBIN;
   assign ack_s  = ACKIN;
`endif

   arb_state_t         state_q, state_d;
   logic [ID_W-1:0]    grant_q, grant_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [ID_W-1:0]    ptr_next;
   logic [MAX_REQ-1:0] req_ext;

   always_comb begin
      req_ext = '0;
      req_ext[N_REQ-1:0] = send_s;
   end

   // Explicit wrap so non-power-of-two N_REQ returns to 0.
   assign ptr_next = (grant_q == ID_W'(N_REQ-1)) ? '0 : grant_q + 1'b1;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (!ack_s && (|send_s)) begin
               grant_d = ID_W'(rr_pick(req_ext, 4'(ptr_q), N_REQ));
               state_d = exb_s[grant_d] ? FWD : ABSORB;
            end
         end
         FWD:    if (ack_s)            state_d = ACK;
         ACK:    if (!send_s[grant_q]) state_d = RTZ;
         RTZ:    if (!ack_s)           state_d = DONE;
         DONE: begin
            ptr_d   = ptr_next;
            state_d = IDLE;
         end
         ABSORB: begin
            if (!send_s[grant_q]) begin
               ptr_d   = ptr_next;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are flopped from the next-state decode so they change on the
   // same edge as the state itself.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         SENDOUT <= 1'b0;
         ACKOUT  <= '0;
         CP      <= 1'b0;
         BUSY    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         SENDOUT <= (state_d == FWD) || (state_d == ACK);
         ACKOUT  <= ((state_d == ACK) || (state_d == RTZ) || (state_d == ABSORB))
                    ? (N_REQ'(1) << grant_d) : '0;
         CP      <= (state_d == DONE);
         BUSY    <= (state_d != IDLE);
      end
   end

   assign GRANT_ID = grant_q;

endmodule
